// File: rtl/led_pattern_sequencer_if.sv
// Bundle of the sequencer's button, pattern-source and LED signals.
// The environment drives through master; the sequencer connects as slave.
interface led_pattern_sequencer_if;
    logic       btn;        // raw asynchronous mode button, active high
    logic       auto_en;    // auto-cycle enable, synchronous level
    logic [7:0] pat_gray;   // external gray-counter pattern
    logic [7:0] pat_rng;    // external random pattern
    logic       step_gray;  // advance strobe to the gray source
    logic       step_rng;   // advance strobe to the rng source
    logic [1:0] mode;       // current display mode
    logic       blanking;   // high while LEDs are blanked between modes
    logic [7:0] leds;       // registered LED drive, bit 7 = LED1

    modport master (
        output btn, auto_en, pat_gray, pat_rng,
        input  step_gray, step_rng, mode, blanking, leds
    );

    modport slave (
        input  btn, auto_en, pat_gray, pat_rng,
        output step_gray, step_rng, mode, blanking, leds
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: debounced button or auto timer steps through four
// display modes (gray, rng, walking one, bar), with a dark gap between modes.
module led_pattern_sequencer #(
    parameter int LOG2DELAY     = 22,
    parameter int DEBOUNCE_BITS = 16,
    parameter int AUTO_TICKS    = 64,
    parameter int BLANK_TICKS   = 2
) (
    input  logic clk,
    input  logic rst,
    led_pattern_sequencer_if.slave bus
);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    localparam logic [1:0] MODE_GRAY = 2'd0;
    localparam logic [1:0] MODE_RNG  = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;
    localparam logic [1:0] MODE_BAR  = 2'd3;

    localparam logic [7:0] AUTO_LAST  = 8'(AUTO_TICKS - 1);
    localparam logic [3:0] BLANK_LAST = 4'(BLANK_TICKS - 1);

    logic [LOG2DELAY-1:0]     presc_q;
    logic                     tick;
    logic                     sync1_q, sync2_q;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q;
    logic                     stable_q, stable_dly_q;
    logic                     press;
    logic [7:0]               auto_q;
    logic                     auto_adv;
    logic                     advance;
    logic                     show_tick;
    state_e                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [3:0]               blank_q, blank_d;
    logic [7:0]               walk_q, bar_q;
    logic [7:0]               leds_q, leds_d;

    // Free-running prescaler; tick marks the all-ones cycle before the wrap.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_q + 1'b1;
    end

    assign tick      = &presc_q;
    assign show_tick = tick & (state_q == ST_SHOW);

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has persisted for the full count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q     <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            stable_dly_q <= stable_q;
            if (sync2_q != stable_q) begin
                if (&db_cnt_q) begin
                    stable_q <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign press    = stable_q & ~stable_dly_q;
    assign auto_adv = show_tick & bus.auto_en & (auto_q == AUTO_LAST);
    // Requests during BLANK are dropped here rather than remembered.
    assign advance  = (state_q == ST_SHOW) & (press | auto_adv);

    // Auto-cycle tick counter, restarted by every accepted advance.
    always_ff @(posedge clk) begin
        if (rst || !bus.auto_en) auto_q <= '0;
        else if (advance)        auto_q <= '0;
        else if (show_tick)      auto_q <= auto_q + 8'd1;
    end

    // FSM state, mode and blank-gap counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SHOW;
            mode_q  <= MODE_GRAY;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            blank_q <= blank_d;
        end
    end

    // FSM next state: advance into BLANK, return to SHOW after the gap.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        blank_d = blank_q;
        unique case (state_q)
            ST_SHOW: begin
                if (advance) begin
                    state_d = ST_BLANK;
                    mode_d  = mode_q + 2'd1;
                    blank_d = '0;
                end
            end
            ST_BLANK: begin
                if (tick) begin
                    if (blank_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_SHOW;
        endcase
    end

    // Internal walking-one and thermometer patterns, stepped only while shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            walk_q <= 8'h01;
            bar_q  <= 8'h00;
        end else begin
            if (show_tick && mode_q == MODE_WALK)
                walk_q <= {walk_q[6:0], walk_q[7]};
            if (show_tick && mode_q == MODE_BAR)
                bar_q <= (bar_q == 8'hFF) ? 8'h00 : {bar_q[6:0], 1'b1};
        end
    end

    // LED source select; dark during the gap between modes.
    always_comb begin
        leds_d = 8'h00;
        if (state_q == ST_SHOW) begin
            unique case (mode_q)
                MODE_GRAY: leds_d = bus.pat_gray;
                MODE_RNG:  leds_d = bus.pat_rng;
                MODE_WALK: leds_d = walk_q;
                MODE_BAR:  leds_d = bar_q;
                default:   leds_d = 8'h00;
            endcase
        end
    end

    // Registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) leds_q <= 8'h00;
        else     leds_q <= leds_d;
    end

    assign bus.step_gray = show_tick & (mode_q == MODE_GRAY);
    assign bus.step_rng  = show_tick & (mode_q == MODE_RNG);
    assign bus.mode      = mode_q;
    assign bus.blanking  = (state_q == ST_BLANK);
    assign bus.leds      = leds_q;

endmodule
